fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 159 +++++++++++++++
 tb/tb_fetch_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - halfword instruction fetch with prefetch buffer
//
// Fetches 16-bit instructions from a single-outstanding instruction memory
// port into a small circular prefetch buffer and hands them to decode.
//
// Ports:
//   clk_i, rst_i                : clock, synchronous active-high reset
//   imem_req_o / imem_addr_o    : one-cycle read request and its halfword address
//   imem_ack_i / imem_data_i    : read response (one or more cycles after the request)
//   stall_i                     : decode cannot take an instruction this cycle
//   branch_i / branch_target_i  : redirect from execute (flushes the buffer)
//   halt_i                      : end of program, fetch stops until reset
//   instr_o, programm_counter_o : buffer head and its address (0 when empty)
//   next_programm_counter_o     : programm_counter_o + 2
//   instr_en_o                  : instr_o valid and consumed this cycle
//   halted_o                    : fetch stopped

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [15:0] imem_data_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        halt_i,
  output logic [15:0] instr_o,
  output logic [31:0] programm_counter_o,
  output logic [31:0] next_programm_counter_o,
  output logic        instr_en_o,
  output logic        halted_o
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} state_t;

  state_t        state;
  logic [31:0]   fpc;
  logic [31:0]   req_addr;
  logic          drop;
  logic [15:0]   buf_data [BUF_DEPTH];
  logic [31:0]   buf_addr [BUF_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          empty;
  logic          outstanding;
  logic          push;
  logic          pop;
  logic          can_issue;
  logic [CW:0]   occ_next;
  logic          unused_target_lsb;

  assign unused_target_lsb = branch_target_i[0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count == '0);
  // In RUN or HALT a set drop flag means an abandoned request still owes an ack.
  assign outstanding = (state == S_WAIT) || drop;

  always_comb begin
    pop  = 1'b0;
    push = 1'b0;
    occ_next  = '0;
    can_issue = 1'b0;
    pop  = !rst_i && !empty && !stall_i && (state != S_HALT) && !halt_i && !branch_i;
    push = !rst_i && (state == S_WAIT) && imem_ack_i && !drop && !branch_i && !halt_i;
    // Occupancy after this cycle's push and pop; counting the pop keeps
    // zero-wait memory at one instruction per cycle with only two entries.
    occ_next = (CW+1)'(count) + (CW+1)'(push) - (CW+1)'(pop);
    // A new request may follow an ack in the same cycle. After a reset that
    // abandoned a request, RUN waits for the stale ack so that at most one
    // request is ever in flight.
    can_issue = !rst_i && !branch_i && !halt_i &&
                (((state == S_RUN) && !drop) || ((state == S_WAIT) && imem_ack_i)) &&
                (occ_next < (CW+1)'(BUF_DEPTH));
  end

  assign imem_req_o              = can_issue;
  assign imem_addr_o             = fpc;
  assign instr_en_o              = pop;
  assign instr_o                 = empty ? 16'h0000 : buf_data[head];
  assign programm_counter_o      = empty ? 32'h0000_0000 : buf_addr[head];
  assign next_programm_counter_o = programm_counter_o + 32'd2;
  assign halted_o                = (state == S_HALT);

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_data[tail] <= imem_data_i;
      buf_addr[tail] <= req_addr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_RUN;
      fpc      <= RESET_PC;
      req_addr <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      drop     <= outstanding && !imem_ack_i;
    end else if (state == S_HALT) begin
      if (imem_ack_i) drop <= 1'b0;
    end else if (halt_i) begin
      // Halt wins over a simultaneous branch.
      state <= S_HALT;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      drop  <= outstanding && !imem_ack_i;
    end else begin
      if (branch_i) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        fpc   <= {branch_target_i[31:1], 1'b0};
      end else begin
        if (push) tail <= ptr_inc(tail);
        if (pop)  head <= ptr_inc(head);
        count <= CW'(occ_next);
        if (can_issue) fpc <= fpc + 32'd2;
      end

      case (state)
        S_RUN: begin
          if (imem_ack_i && drop) begin
            drop <= 1'b0;
          end else if (can_issue) begin
            state    <= S_WAIT;
            req_addr <= fpc;
          end
        end
        S_WAIT: begin
          if (imem_ack_i) begin
            drop <= 1'b0;
            if (can_issue) req_addr <= fpc;
            else           state    <= S_RUN;
          end else if (branch_i) begin
            drop <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst, stall, branch, halt;
  logic [31:0] target;
  logic [1:0] req, ack, instr_en, halted;
  logic [1:0][31:0] addr, pc, npc;
  logic [1:0][15:0] rdata, instr;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat      = 1;
  int   rc       = 0;
  int   n_req [2];
  logic [1:0] chk_en = 2'b00;
  logic [1:0] pend   = 2'b00;
  int   rem   [2];
  logic [31:0] paddr [2];
  exp_t q0[$];
  exp_t q1[$];

  fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(req[0]), .imem_addr_o(addr[0]),
    .imem_ack_i(ack[0]), .imem_data_i(rdata[0]),
    .stall_i(stall), .branch_i(branch), .branch_target_i(target), .halt_i(halt),
    .instr_o(instr[0]), .programm_counter_o(pc[0]), .next_programm_counter_o(npc[0]),
    .instr_en_o(instr_en[0]), .halted_o(halted[0])
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) u_dut_wrap (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(req[1]), .imem_addr_o(addr[1]),
    .imem_ack_i(ack[1]), .imem_data_i(rdata[1]),
    .stall_i(stall), .branch_i(branch), .branch_target_i(target), .halt_i(halt),
    .instr_o(instr[1]), .programm_counter_o(pc[1]), .next_programm_counter_o(npc[1]),
    .instr_en_o(instr_en[1]), .halted_o(halted[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] word(input logic [31:0] a);
    return a[16:1] ^ a[31:16] ^ 16'hC3A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int w);
    return (w == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push_exp(input int w, input logic [31:0] p, input int c);
    exp_t e;
    e.pc = p;
    e.cyc = c;
    if (w == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Memory model: ack lat cycles after the request, data is a function of the address.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pend[i] && rem[i] > 0) rem[i]--;
      ack[i]   = pend[i] && (rem[i] == 0);
      rdata[i] = ack[i] ? word(paddr[i]) : 16'hDEAD;
    end
    #4;
    for (int i = 0; i < 2; i++) begin
      if (ack[i]) pend[i] = 1'b0;
      if (req[i]) begin
        chk($sformatf("one_outstanding%0d", i), {31'b0, pend[i]}, 32'd0);
        n_req[i]++;
        pend[i]  = 1'b1;
        rem[i]   = lat;
        paddr[i] = addr[i];
      end
    end
  end

  // Monitor: pop the scoreboard on every delivered instruction.
  always @(negedge clk) begin
    #4;
    if (rst) begin
      rc = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (chk_en[i] && instr_en[i]) begin
          if (qsize(i) == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_delivery%0d: got pc %h required no delivery", i, pc[i]);
          end else begin
            exp_t e;
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("pc%0d", i), pc[i], e.pc);
            chk($sformatf("instr%0d", i), {16'h0, instr[i]}, {16'h0, word(e.pc)});
            chk($sformatf("next_pc%0d", i), npc[i], e.pc + 32'd2);
            if (e.cyc >= 0) chk($sformatf("deliver_cycle%0d", i), 32'(rc), 32'(e.cyc));
          end
        end
      end
      rc++;
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    #4;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_req%0d", i), {31'b0, req[i]}, 32'd0);
      chk($sformatf("rst_en%0d", i), {31'b0, instr_en[i]}, 32'd0);
      chk($sformatf("rst_halted%0d", i), {31'b0, halted[i]}, 32'd0);
      chk($sformatf("rst_instr%0d", i), {16'h0, instr[i]}, 32'd0);
      chk($sformatf("rst_pc%0d", i), pc[i], 32'd0);
      chk($sformatf("rst_npc%0d", i), npc[i], 32'd2);
    end
  endtask

  task automatic release_rst(input int w, input logic [31:0] exp_addr);
    @(negedge clk);
    rst = 1'b0;
    #4;
    chk($sformatf("first_req%0d", w), {31'b0, req[w]}, 32'd1);
    chk($sformatf("first_addr%0d", w), addr[w], exp_addr);
  endtask

  task automatic drain(input int w);
    int t;
    t = 0;
    while (qsize(w) != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("drain%0d", w), 32'(qsize(w)), 32'd0);
  endtask

  initial begin
    int base;
    rst = 1'b1; stall = 1'b1; branch = 1'b0; halt = 1'b0; target = 32'h0;
    ack = 2'b00; rdata = '0; n_req[0] = 0; n_req[1] = 0;
    do_reset(6);

    // Zero-wait streaming: deliveries in cycles 2..5.
    chk_en = 2'b01;
    push_exp(0, 32'h0, 2); push_exp(0, 32'h2, 3);
    push_exp(0, 32'h4, 4); push_exp(0, 32'h6, 5);
    stall = 1'b0;
    release_rst(0, 32'h0);
    drain(0);
    stall = 1'b1;

    // Stall for five cycles: buffer fills, then in-order delivery.
    do_reset(6);
    base = n_req[0];
    release_rst(0, 32'h0);
    repeat (5) @(negedge clk);
    chk("stall_reqs", 32'(n_req[0] - base), 32'd2);
    for (int k = 0; k < 5; k++) push_exp(0, 32'(2 * k), -1);
    stall = 1'b0;
    drain(0);
    stall = 1'b1;

    // Branch to an odd target with a 3-cycle request outstanding.
    lat = 3;
    do_reset(6);
    release_rst(0, 32'h0);
    @(negedge clk);
    branch = 1'b1; target = 32'h0000_0101;
    #4;
    chk("branch_no_req", {31'b0, req[0]}, 32'd0);
    @(negedge clk);
    branch = 1'b0;
    push_exp(0, 32'h100, -1); push_exp(0, 32'h102, -1); push_exp(0, 32'h104, -1);
    stall = 1'b0;
    drain(0);
    stall = 1'b1;

    // Branch in the cycle of an ack and a would-be pop.
    lat = 1;
    stall = 1'b0;
    do_reset(6);
    push_exp(0, 32'h200, -1); push_exp(0, 32'h202, -1); push_exp(0, 32'h204, -1);
    release_rst(0, 32'h0);
    repeat (2) @(negedge clk);
    branch = 1'b1; target = 32'h0000_0200;
    #4;
    chk("branch_blocks_en", {31'b0, instr_en[0]}, 32'd0);
    @(negedge clk);
    branch = 1'b0;
    #4;
    chk("flush_instr", {16'h0, instr[0]}, 32'd0);
    chk("flush_pc", pc[0], 32'd0);
    drain(0);
    stall = 1'b1;

    // Halt mid-stream (with a simultaneous branch), then reset.
    lat = 2;
    stall = 1'b0;
    do_reset(6);
    push_exp(0, 32'h0, -1); push_exp(0, 32'h2, -1);
    release_rst(0, 32'h0);
    drain(0);
    base = n_req[0];
    halt = 1'b1; branch = 1'b1; target = 32'h0000_0300;
    #4;
    chk("halt_blocks_en", {31'b0, instr_en[0]}, 32'd0);
    @(negedge clk);
    halt = 1'b0; branch = 1'b0;
    repeat (5) begin
      #4;
      chk("halted", {31'b0, halted[0]}, 32'd1);
      chk("halt_en", {31'b0, instr_en[0]}, 32'd0);
      @(negedge clk);
    end
    chk("halt_no_req", 32'(n_req[0] - base), 32'd0);

    // Reset mid-WAIT: the stale ack (address 2) must be dropped.
    lat = 3;
    stall = 1'b1;
    do_reset(6);
    release_rst(0, 32'h0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push_exp(0, 32'h0, -1); push_exp(0, 32'h2, -1); push_exp(0, 32'h4, -1);
    stall = 1'b0;
    drain(0);
    stall = 1'b1;

    // RESET_PC near the top of the address space: PC wraps to zero.
    chk_en = 2'b10;
    lat = 1;
    do_reset(6);
    push_exp(1, 32'hFFFF_FFFC, 2); push_exp(1, 32'hFFFF_FFFE, 3);
    push_exp(1, 32'h0000_0000, 4); push_exp(1, 32'h0000_0002, 5);
    stall = 1'b0;
    release_rst(1, 32'hFFFF_FFFC);
    drain(1);
    stall = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
